// File: rtl/gmii2fifo_pack.sv
// GMII receive byte stream packer: gathers LANES bytes per FIFO word with a byte-valid
// mask, end-of-frame and error flags, optional preamble strip and full-driven frame drop.
module gmii2fifo_pack #(
  parameter int         LANES          = 8,
  parameter logic [3:0] GAP            = 4'h2,
  parameter bit         STRIP_PREAMBLE = 1'b0
) (
  input  logic                 gmii_rx_clk,
  input  logic                 sys_rst_n,
  input  logic                 gmii_rx_dv,
  input  logic                 gmii_rx_er,
  input  logic [7:0]           gmii_rxd,
  output logic [LANES*9+1:0]   din,
  input  logic                 full,
  output logic                 wr_en,
  output logic                 wr_clk,
  output logic [15:0]          frame_count,
  output logic [15:0]          drop_count
);

  localparam int W    = LANES * 9 + 2;
  localparam int DW   = LANES * 8;
  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(LANES - 1);
  localparam logic [7:0] SFD = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_RECV,
    S_TERM,
    S_GAP,
    S_DROP
  } state_t;

  localparam state_t POST_EOF = (GAP == 4'd0) ? S_IDLE : S_GAP;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [DW-1:0]   data_q, data_d;
  logic [LANES-1:0] mask_q, mask_d;
  logic            err_q, err_d;
  logic [3:0]      gap_q, gap_d;
  logic            infrm_q, infrm_d;
  logic            wait_q, wait_d;
  logic            wr_en_q, wr_en_d;
  logic [W-1:0]    din_q, din_d;
  logic [15:0]     fcnt_q, fcnt_d;
  logic [15:0]     dcnt_q, dcnt_d;

  logic            start, cap, req;
  logic [W-1:0]    req_word;
  logic [DW-1:0]   data_n;
  logic [LANES-1:0] mask_n;

  function automatic logic [W-1:0] pack(input logic eof, input logic err,
                                        input logic [LANES-1:0] m,
                                        input logic [DW-1:0] d);
    return {eof, err, m, d};
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    mask_d   = mask_q;
    err_d    = err_q;
    gap_d    = gap_q;
    infrm_d  = infrm_q;
    wait_d   = wait_q & gmii_rx_dv;
    wr_en_d  = 1'b0;
    din_d    = '0;
    dcnt_d   = dcnt_q;
    start    = 1'b0;
    cap      = 1'b0;
    req      = 1'b0;
    req_word = '0;
    data_n   = data_q;
    mask_n   = mask_q;

    case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv && !wait_q) start = 1'b1;
      end
      S_PRE: begin
        if (!gmii_rx_dv) begin
          state_d = S_IDLE;
        end else begin
          err_d = err_q | gmii_rx_er;
          if (gmii_rxd == SFD) state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (gmii_rx_dv) begin
          err_d = err_q | gmii_rx_er;
          cap   = 1'b1;
        end else if (idx_q != '0) begin
          req      = 1'b1;
          req_word = pack(1'b1, err_q, mask_q, data_q);
          idx_d    = '0;
          gap_d    = GAP;
          state_d  = POST_EOF;
        end else begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        req      = 1'b1;
        req_word = pack(1'b1, err_q, '0, '0);
        gap_d    = GAP;
        state_d  = POST_EOF;
      end
      S_GAP: begin
        if (gmii_rx_dv) begin
          start = 1'b1;
        end else if (!full) begin
          wr_en_d = 1'b1;
          if (gap_q <= 4'd1) state_d = S_IDLE;
          else               gap_d   = gap_q - 4'd1;
        end
      end
      S_DROP: begin
        if (gmii_rx_dv) begin
          // A frame starting before the error terminator goes out is lost too.
          if (!infrm_q) begin
            dcnt_d  = dcnt_q + 16'd1;
            infrm_d = 1'b1;
          end
        end else begin
          infrm_d = 1'b0;
          if (!full) begin
            wr_en_d = 1'b1;
            din_d   = pack(1'b1, 1'b1, '0, '0);
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      err_d = gmii_rx_er;
      idx_d = '0;
      if (STRIP_PREAMBLE) begin
        state_d = S_PRE;
      end else begin
        state_d = S_RECV;
        cap     = 1'b1;
      end
    end

    // Lane 0 opens a fresh word, so stale bytes never leak into a partial word.
    if (cap) begin
      if (idx_q == '0) begin
        data_n = '0;
        mask_n = '0;
      end
      for (int k = 0; k < LANES; k++) begin
        if (idx_q == IDXW'(k)) begin
          data_n[k*8 +: 8] = gmii_rxd;
          mask_n[k]        = 1'b1;
        end
      end
      data_d = data_n;
      mask_d = mask_n;
      if (idx_q == LAST) begin
        idx_d    = '0;
        req      = 1'b1;
        req_word = pack(1'b0, 1'b0, mask_n, data_n);
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (req) begin
      if (full) begin
        state_d = S_DROP;
        idx_d   = '0;
        infrm_d = gmii_rx_dv;
        dcnt_d  = dcnt_q + 16'd1;
      end else begin
        wr_en_d = 1'b1;
        din_d   = req_word;
      end
    end

    fcnt_d = fcnt_q + ((wr_en_d && din_d[W-1] && !din_d[W-2]) ? 16'd1 : 16'd0);
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      gap_q   <= '0;
      infrm_q <= 1'b0;
      wait_q  <= 1'b1;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      infrm_q <= infrm_d;
      wait_q  <= wait_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Word accumulator is fully rewritten from lane 0 on every frame start.
  always_ff @(posedge gmii_rx_clk) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end

  assign wr_clk      = gmii_rx_clk;
  assign wr_en       = wr_en_q;
  assign din         = din_q;
  assign frame_count = fcnt_q;
  assign drop_count  = dcnt_q;

endmodule

// File: tb/tb_gmii2fifo_pack.sv
// Directed bench for gmii2fifo_pack: three instances (8-lane, 4-lane no gap,
// 4-lane preamble strip) driven from one shared GMII stream.
module tb_gmii2fifo_pack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic       er = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic       full = 1'b0;

  logic [73:0] din8;
  logic        wr8, wclk8;
  logic [15:0] fc8, dc8;
  logic [37:0] din4;
  logic        wr4, wclk4;
  logic [15:0] fc4, dc4;
  logic [37:0] dins;
  logic        wrs, wclks;
  logic [15:0] fcs, dcs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gmii2fifo_pack #(.LANES(8), .GAP(4'h2), .STRIP_PREAMBLE(1'b0)) u8 (
    .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .gmii_rxd(rxd), .din(din8), .full(full), .wr_en(wr8), .wr_clk(wclk8),
    .frame_count(fc8), .drop_count(dc8));

  gmii2fifo_pack #(.LANES(4), .GAP(4'h0), .STRIP_PREAMBLE(1'b0)) u4 (
    .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .gmii_rxd(rxd), .din(din4), .full(full), .wr_en(wr4), .wr_clk(wclk4),
    .frame_count(fc4), .drop_count(dc4));

  gmii2fifo_pack #(.LANES(4), .GAP(4'h1), .STRIP_PREAMBLE(1'b1)) us (
    .gmii_rx_clk(clk), .sys_rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .gmii_rxd(rxd), .din(dins), .full(full), .wr_en(wrs), .wr_clk(wclks),
    .frame_count(fcs), .drop_count(dcs));

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] b, input logic e);
    dv  = v;
    rxd = b;
    er  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    drv(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    chk("rst_wr8", 80'(wr8), 80'(0));
    chk("rst_din8", 80'(din8), 80'(0));
    chk("rst_fc8", 80'(fc8), 80'(0));
    chk("rst_dc8", 80'(dc8), 80'(0));
    chk("rst_wr4", 80'(wr4), 80'(0));
    chk("rst_wrs", 80'(wrs), 80'(0));
    chk("wr_clk", 80'(wclk8), 80'(clk));
    rst_n = 1'b1;
    drv(1'b0, 8'h00, 1'b0);

    // 16-byte frame, 8 lanes: two full words, terminator, two gap words
    for (int i = 1; i <= 16; i++) begin
      drv(1'b1, 8'(i), 1'b0);
      if (i == 7)  chk("f16_wr_b7", 80'(wr8), 80'(0));
      if (i == 8) begin
        chk("f16_wr_w1", 80'(wr8), 80'(1));
        chk("f16_din_w1", 80'(din8), 80'({2'b00, 8'hFF, 64'h0807060504030201}));
      end
      if (i == 16) begin
        chk("f16_wr_w2", 80'(wr8), 80'(1));
        chk("f16_din_w2", 80'(din8), 80'({2'b00, 8'hFF, 64'h100F0E0D0C0B0A09}));
      end
    end
    drv(1'b0, 8'h00, 1'b0);
    chk("f16_term_wait", 80'(wr8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("f16_term_wr", 80'(wr8), 80'(1));
    chk("f16_term_din", 80'(din8), 80'({1'b1, 1'b0, 8'h00, 64'h0}));
    chk("f16_fc", 80'(fc8), 80'(1));
    drv(1'b0, 8'h00, 1'b0);
    chk("f16_gap1_wr", 80'(wr8), 80'(1));
    chk("f16_gap1_din", 80'(din8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("f16_gap2_wr", 80'(wr8), 80'(1));
    chk("f16_gap2_din", 80'(din8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("f16_idle_wr", 80'(wr8), 80'(0));

    // 5-byte frame, 4 lanes, no gap
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drv(1'b1, 8'(i), 1'b0);
      if (i == 4) begin
        chk("l4_wr_w1", 80'(wr4), 80'(1));
        chk("l4_din_w1", 80'(din4), 80'({2'b00, 4'hF, 32'h04030201}));
      end
      if (i == 5) chk("l4_wr_b5", 80'(wr4), 80'(0));
    end
    drv(1'b0, 8'h00, 1'b0);
    chk("l4_wr_eof", 80'(wr4), 80'(1));
    chk("l4_din_eof", 80'(din4), 80'({1'b1, 1'b0, 4'h1, 32'h00000005}));
    chk("l4_fc", 80'(fc4), 80'(1));
    drv(1'b0, 8'h00, 1'b0);
    chk("l4_nogap_wr", 80'(wr4), 80'(0));

    // Preamble strip: 55 x7, D5, AA, BB
    do_reset();
    for (int i = 0; i < 7; i++) drv(1'b1, 8'h55, 1'b0);
    drv(1'b1, 8'hD5, 1'b0);
    chk("pre_wr_sfd", 80'(wrs), 80'(0));
    drv(1'b1, 8'hAA, 1'b0);
    drv(1'b1, 8'hBB, 1'b0);
    chk("pre_wr_bb", 80'(wrs), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("pre_wr_eof", 80'(wrs), 80'(1));
    chk("pre_din_eof", 80'(dins), 80'({1'b1, 1'b0, 4'h3, 32'h0000BBAA}));
    chk("pre_fc", 80'(fcs), 80'(1));
    drv(1'b0, 8'h00, 1'b0);
    chk("pre_gap_wr", 80'(wrs), 80'(1));
    chk("pre_gap_din", 80'(dins), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("pre_idle_wr", 80'(wrs), 80'(0));

    // rx_er on byte 3 of a 10-byte frame
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drv(1'b1, 8'(i), (i == 3));
      if (i == 8) chk("er_din_w1", 80'(din8), 80'({2'b00, 8'hFF, 64'h0807060504030201}));
    end
    drv(1'b0, 8'h00, 1'b0);
    chk("er_wr_eof", 80'(wr8), 80'(1));
    chk("er_din_eof", 80'(din8), 80'({1'b1, 1'b1, 8'h03, 64'h0000000000000A09}));
    chk("er_fc", 80'(fc8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    chk("er_idle_wr", 80'(wr8), 80'(0));

    // FIFO full across the second word of a 16-byte frame
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) full = 1'b1;
      drv(1'b1, 8'(i), 1'b0);
      if (i == 8) chk("full_wr_w1", 80'(wr8), 80'(1));
      if (i == 16) begin
        chk("full_wr_w2", 80'(wr8), 80'(0));
        chk("full_dc", 80'(dc8), 80'(1));
      end
    end
    drv(1'b0, 8'h00, 1'b0);
    chk("full_wr_held", 80'(wr8), 80'(0));
    full = 1'b0;
    drv(1'b0, 8'h00, 1'b0);
    chk("full_wr_errw", 80'(wr8), 80'(1));
    chk("full_din_errw", 80'(din8), 80'({1'b1, 1'b1, 8'h00, 64'h0}));
    chk("full_fc", 80'(fc8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("full_nogap_wr", 80'(wr8), 80'(0));
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 8'(8'h21 + i), 1'b0);
      if (i == 7) chk("full_next_din", 80'(din8), 80'({2'b00, 8'hFF, 64'h2827262524232221}));
    end
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    chk("full_next_eof", 80'(din8), 80'({1'b1, 1'b0, 8'h00, 64'h0}));
    chk("full_next_fc", 80'(fc8), 80'(1));
    chk("full_next_dc", 80'(dc8), 80'(1));
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);

    // Reset asserted mid-word, frame continues after release
    for (int i = 1; i <= 3; i++) drv(1'b1, 8'(8'h40 + i), 1'b0);
    rst_n = 1'b0;
    drv(1'b1, 8'h44, 1'b0);
    chk("mrst_wr", 80'(wr8), 80'(0));
    chk("mrst_din", 80'(din8), 80'(0));
    chk("mrst_fc", 80'(fc8), 80'(0));
    chk("mrst_dc", 80'(dc8), 80'(0));
    rst_n = 1'b1;
    drv(1'b1, 8'h45, 1'b0);
    drv(1'b1, 8'h46, 1'b0);
    chk("mrst_tail_wr", 80'(wr8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("mrst_noeof_wr", 80'(wr8), 80'(0));
    drv(1'b0, 8'h00, 1'b0);
    chk("mrst_idle_wr", 80'(wr8), 80'(0));
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 8'(8'h31 + i), 1'b0);
      if (i == 7) begin
        chk("mrst_next_wr", 80'(wr8), 80'(1));
        chk("mrst_next_din", 80'(din8), 80'({2'b00, 8'hFF, 64'h3837363534333231}));
      end
    end
    drv(1'b0, 8'h00, 1'b0);
    drv(1'b0, 8'h00, 1'b0);
    chk("mrst_next_fc", 80'(fc8), 80'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
